// File: rtl/conv_row_scheduler_if.sv
// Handshake bundle between the row scheduler and its PE-array/Accumulator environment.
// master: scheduler side; slave: the environment that starts layers and returns results.
interface conv_row_scheduler_if #(
  parameter int K      = 3,
  parameter int IFM_H  = 32,
  parameter int IFM_W  = 32,
  parameter int OUT_CH = 512
);
  logic                      start;
  logic                      stall;
  logic                      acc_out_valid;
  logic                      pe_valid;
  logic [$clog2(K)-1:0]      row_idx;
  logic [$clog2(IFM_W)-1:0]  ox;
  logic [$clog2(IFM_H)-1:0]  oy;
  logic [$clog2(OUT_CH)-1:0] oc;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    input  start, stall, acc_out_valid,
    output pe_valid, row_idx, ox, oy, oc, busy, done, err
  );

  modport slave (
    output start, stall, acc_out_valid,
    input  pe_valid, row_idx, ox, oy, oc, busy, done, err
  );
endinterface

// File: rtl/conv_row_scheduler.sv
// Issues K kernel-row beats per output pixel of a stride-1 KxK layer, limits
// outstanding Accumulator results and reports completion.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_ISSUE | issuing row beats, one per cycle
//   S_DRAIN | all beats issued, waiting for remaining results
//   S_DONE  | one-cycle completion pulse
module conv_row_scheduler #(
  parameter int K         = 3,
  parameter int IN_CH     = 512,
  parameter int IFM_H     = 32,
  parameter int IFM_W     = 32,
  parameter int OUT_CH    = 512,
  parameter int MAX_OUTST = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_row_scheduler_if.master if_sched
);

  localparam int OH    = IFM_H - K + 1;
  localparam int OW    = IFM_W - K + 1;
  localparam int TOTAL = OUT_CH * OH * OW;

  localparam int RW = $clog2(K);
  localparam int XW = $clog2(IFM_W);
  localparam int YW = $clog2(IFM_H);
  localparam int CW = $clog2(OUT_CH);
  localparam int SW = $clog2(MAX_OUTST + 1);
  localparam int NW = $clog2(TOTAL + 1);

  localparam logic [RW-1:0] ROW_LAST  = RW'(K - 1);
  localparam logic [XW-1:0] OX_LAST   = XW'(OW - 1);
  localparam logic [YW-1:0] OY_LAST   = YW'(OH - 1);
  localparam logic [CW-1:0] OC_LAST   = CW'(OUT_CH - 1);
  localparam logic [SW-1:0] OST_MAX   = SW'(MAX_OUTST);
  localparam logic [NW-1:0] CNT_TOTAL = NW'(TOTAL);

  if (K < 2 || IFM_H < K + 1 || IFM_W < K + 1 || OUT_CH < 2 || MAX_OUTST < 1 || IN_CH < 1)
  begin : g_param_check
    $error("conv_row_scheduler: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [RW-1:0] r_row;
  logic [XW-1:0] r_ox;
  logic [YW-1:0] r_oy;
  logic [CW-1:0] r_oc;
  logic [SW-1:0] r_outst;
  logic [NW-1:0] r_out_cnt;
  logic          r_err;

  logic          w_beat;
  logic          w_clear;
  logic          w_busy;
  logic          w_done;
  logic          w_boundary;
  logic          w_row_last;
  logic          w_pix_last;
  logic          w_can_open;
  logic          w_inc;
  logic          w_ret_ok;
  logic          w_err_set;
  logic [NW-1:0] w_cnt_nxt;

  assign w_boundary = (r_row == '0);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_pix_last = (r_ox == OX_LAST) && (r_oy == OY_LAST) && (r_oc == OC_LAST);
  assign w_can_open = !if_sched.stall && (r_outst < OST_MAX);

  // A result is only accepted against an issued pixel; anything else is a protocol error.
  assign w_ret_ok  = if_sched.acc_out_valid && (r_state != S_IDLE) && (r_outst != '0);
  assign w_err_set = if_sched.acc_out_valid && ((r_state == S_IDLE) || (r_outst == '0));
  assign w_inc     = w_beat && w_row_last;
  assign w_cnt_nxt = r_out_cnt + NW'(w_ret_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    w_clear     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_sched.start) begin
          w_clear     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_busy = 1'b1;
        // stall and the outstanding limit only gate the first row of a pixel
        if (!w_boundary || w_can_open) begin
          w_beat = 1'b1;
          if (w_row_last && w_pix_last) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_cnt_nxt == CNT_TOTAL) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Issue indices: row fastest, then ox, oy, oc. The final pixel leaves them parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_ox  <= '0;
      r_oy  <= '0;
      r_oc  <= '0;
    end else if (w_clear) begin
      r_row <= '0;
      r_ox  <= '0;
      r_oy  <= '0;
      r_oc  <= '0;
    end else if (w_beat) begin
      if (!w_row_last) begin
        r_row <= r_row + RW'(1);
      end else if (!w_pix_last) begin
        r_row <= '0;
        if (r_ox != OX_LAST) begin
          r_ox <= r_ox + XW'(1);
        end else begin
          r_ox <= '0;
          if (r_oy != OY_LAST) begin
            r_oy <= r_oy + YW'(1);
          end else begin
            r_oy <= '0;
            r_oc <= (r_oc == OC_LAST) ? '0 : r_oc + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= '0;
    end else begin
      case ({w_inc, w_ret_ok})
        2'b10:   r_outst <= r_outst + SW'(1);
        2'b01:   r_outst <= r_outst - SW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt <= '0;
    end else if (w_clear) begin
      r_out_cnt <= '0;
    end else begin
      r_out_cnt <= w_cnt_nxt;
    end
  end

  // A spurious result wins over a same-cycle start so the error is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_clear) begin
      r_err <= 1'b0;
    end
  end

  assign if_sched.pe_valid = w_beat;
  assign if_sched.row_idx  = r_row;
  assign if_sched.ox       = r_ox;
  assign if_sched.oy       = r_oy;
  assign if_sched.oc       = r_oc;
  assign if_sched.busy     = w_busy;
  assign if_sched.done     = w_done;
  assign if_sched.err      = r_err;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench for conv_row_scheduler: K=3, 4x4 input, 2 output channels, with
// behavioural Accumulators returning one result a fixed delay after each row-2 beat.
module tb_conv_row_scheduler;
  localparam int K  = 3;
  localparam int IH = 4;
  localparam int IW = 4;
  localparam int OC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  int   cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  conv_row_scheduler_if #(.K(K), .IFM_H(IH), .IFM_W(IW), .OUT_CH(OC)) bus_a ();
  conv_row_scheduler_if #(.K(K), .IFM_H(IH), .IFM_W(IW), .OUT_CH(OC)) bus_b ();

  conv_row_scheduler #(.K(K), .IN_CH(8), .IFM_H(IH), .IFM_W(IW), .OUT_CH(OC), .MAX_OUTST(4))
    u_dut_a (.clk(clk), .rst_n(rst_n_a), .if_sched(bus_a));
  conv_row_scheduler #(.K(K), .IN_CH(8), .IFM_H(IH), .IFM_W(IW), .OUT_CH(OC), .MAX_OUTST(1))
    u_dut_b (.clk(clk), .rst_n(rst_n_b), .if_sched(bus_b));

  // Accumulator models: latency 2 for A, latency 5 for B.
  logic       inj_a = 1'b0;
  logic [1:0] q_a   = '0;
  logic [4:0] q_b   = '0;
  always @(posedge clk) begin
    q_a <= {q_a[0], bus_a.pe_valid && (bus_a.row_idx == 2'd2)};
    q_b <= {q_b[3:0], bus_b.pe_valid && (bus_b.row_idx == 2'd2)};
  end
  assign bus_a.acc_out_valid = q_a[1] | inj_a;
  assign bus_b.acc_out_valid = q_b[4];

  int         b_cyc [64];
  logic [1:0] b_row [64];
  logic [1:0] b_ox  [64];
  logic [1:0] b_oy  [64];
  logic       b_oc  [64];
  int         nb_a, na_a, nd_a, done_cyc_a, last_acc_a;
  logic       done_busy_a;
  logic       err_log [4096];

  always @(negedge clk) begin
    if (bus_a.pe_valid && nb_a < 64) begin
      b_cyc[nb_a] = cyc;
      b_row[nb_a] = bus_a.row_idx;
      b_ox[nb_a]  = bus_a.ox;
      b_oy[nb_a]  = bus_a.oy;
      b_oc[nb_a]  = bus_a.oc;
      nb_a++;
    end
    if (bus_a.acc_out_valid) begin
      na_a++;
      last_acc_a = cyc;
    end
    if (bus_a.done) begin
      nd_a++;
      done_cyc_a  = cyc;
      done_busy_a = bus_a.busy;
    end
    if (cyc < 4096) err_log[cyc] = bus_a.err;
  end

  int nb_b, na_b, nd_b, np_b, done_cyc_b, last_acc_b;
  int r0_b [8];
  always @(negedge clk) begin
    if (bus_b.pe_valid) begin
      nb_b++;
      if (bus_b.row_idx == 2'd0 && np_b < 8) begin
        r0_b[np_b] = cyc;
        np_b++;
      end
    end
    if (bus_b.acc_out_valid) begin
      na_b++;
      last_acc_b = cyc;
    end
    if (bus_b.done) begin
      nd_b++;
      done_cyc_b = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr_a();
    nb_a = 0; na_a = 0; nd_a = 0; done_cyc_a = 0; last_acc_a = 0; done_busy_a = 1'b1;
  endtask

  task automatic wait_done_a(input int target);
    int n = 0;
    while (nd_a < target && n < 300) begin
      tick();
      n++;
    end
    chk("done_seen_a", 64'(nd_a >= target), 64'd1);
  endtask

  // Checks a full layer on DUT A started at cycle s; pixel 4 onward delayed by gap cycles.
  task automatic check_run_a(input int s, input int gap, input int exp_res, input string tag);
    chk({tag, "_beats"}, 64'(nb_a), 64'd24);
    for (int i = 0; i < 24; i++) begin
      int p  = i / 3;
      int ec = 1 + i + ((i >= 12) ? gap : 0);
      chk($sformatf("%s_beat%0d", tag, i),
          {32'(b_cyc[i] - s), 25'd0, b_row[i], b_oc[i], b_oy[i], b_ox[i]},
          {32'(ec), 25'd0, 2'(i % 3), 1'(p >> 2), 2'((p >> 1) & 1), 2'(p & 1)});
    end
    chk({tag, "_results"}, 64'(na_a), 64'(exp_res));
    chk({tag, "_done_cyc"}, 64'(done_cyc_a - s), 64'(27 + gap));
    chk({tag, "_done_after_acc"}, 64'(done_cyc_a - last_acc_a), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(done_busy_a), 64'd0);
    chk({tag, "_done_pulses"}, 64'(nd_a), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int n;
    bus_a.start = 1'b0; bus_a.stall = 1'b0;
    bus_b.start = 1'b0; bus_b.stall = 1'b0;
    clr_a();
    nb_b = 0; na_b = 0; nd_b = 0; np_b = 0; done_cyc_b = 0; last_acc_b = 0;
    repeat (6) tick();

    chk("reset_a", {bus_a.pe_valid, bus_a.row_idx, bus_a.ox, bus_a.oy, bus_a.oc,
                    bus_a.busy, bus_a.done, bus_a.err}, 64'd0);
    chk("reset_b", {bus_b.pe_valid, bus_b.row_idx, bus_b.ox, bus_b.oy, bus_b.oc,
                    bus_b.busy, bus_b.done, bus_b.err}, 64'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    repeat (2) tick();

    // Basic layer, result latency 2.
    clr_a();
    bus_a.start = 1'b1; s = cyc; tick(); bus_a.start = 1'b0;
    chk("t1_busy_after_start", 64'(bus_a.busy), 64'd1);
    wait_done_a(1);
    chk("t1_done_one_cycle", {bus_a.done, bus_a.busy}, 64'd0);
    check_run_a(s, 0, 8, "t1");
    chk("t1_err", 64'(bus_a.err), 64'd0);

    // MAX_OUTST=1, latency 5: every pixel waits for the previous result.
    bus_b.start = 1'b1; s = cyc; tick(); bus_b.start = 1'b0;
    n = 0;
    while (nd_b < 1 && n < 300) begin tick(); n++; end
    chk("t2_done_seen", 64'(nd_b), 64'd1);
    chk("t2_beats", 64'(nb_b), 64'd24);
    for (int p = 0; p < 8; p++)
      chk($sformatf("t2_row0_pix%0d", p), 64'(r0_b[p] - s), 64'(1 + 8 * p));
    chk("t2_results", 64'(na_b), 64'd8);
    chk("t2_done_cyc", 64'(done_cyc_b - s), 64'd65);
    chk("t2_done_after_acc", 64'(done_cyc_b - last_acc_b), 64'd1);

    // Stall raised during row 1 of pixel 3 for 4 cycles.
    clr_a();
    bus_a.start = 1'b1; s = cyc; tick(); bus_a.start = 1'b0;
    while (cyc < s + 11) tick();
    chk("t3_row1_at_stall", 64'(bus_a.row_idx), 64'd1);
    bus_a.stall = 1'b1;
    while (cyc < s + 15) tick();
    bus_a.stall = 1'b0;
    wait_done_a(1);
    check_run_a(s, 2, 8, "t3");

    // Spurious results: in IDLE, then while nothing is outstanding.
    inj_a = 1'b1; tick(); inj_a = 1'b0;
    chk("t4_err_idle", 64'(bus_a.err), 64'd1);
    tick();
    chk("t4_err_sticky", 64'(bus_a.err), 64'd1);
    clr_a();
    bus_a.start = 1'b1; s = cyc; tick(); bus_a.start = 1'b0;
    chk("t4_err_cleared", 64'(bus_a.err), 64'd0);
    inj_a = 1'b1; tick(); inj_a = 1'b0;
    chk("t4_err_zero_outst", 64'(bus_a.err), 64'd1);
    wait_done_a(1);
    check_run_a(s, 0, 9, "t4");
    chk("t4_err_drain", {err_log[s + 25], err_log[s + 26]}, 64'd3);
    chk("t4_err_after_done", 64'(bus_a.err), 64'd1);
    clr_a();
    bus_a.start = 1'b1; s = cyc; tick(); bus_a.start = 1'b0;
    chk("t4_err_restart", 64'(bus_a.err), 64'd0);
    wait_done_a(1);
    chk("t4_rerun_beats", 64'(nb_a), 64'd24);

    // Reset asserted during DRAIN.
    clr_a();
    bus_a.start = 1'b1; s = cyc; tick(); bus_a.start = 1'b0;
    while (cyc < s + 25) tick();
    chk("t5_in_drain", {bus_a.busy, bus_a.pe_valid}, 64'd2);
    rst_n_a = 1'b0;
    #1;
    chk("t5_async_reset", {bus_a.pe_valid, bus_a.row_idx, bus_a.ox, bus_a.oy, bus_a.oc,
                           bus_a.busy, bus_a.done, bus_a.err}, 64'd0);
    repeat (4) tick();
    chk("t5_no_done", 64'(nd_a), 64'd0);
    rst_n_a = 1'b1;
    tick();
    clr_a();
    bus_a.start = 1'b1; s = cyc; tick(); bus_a.start = 1'b0;
    wait_done_a(1);
    check_run_a(s, 0, 8, "t5");

    // start held high: one layer, then a second beginning right after DONE.
    clr_a();
    bus_a.start = 1'b1; s = cyc;
    wait_done_a(1);
    chk("t6_first_beats", 64'(nb_a), 64'd24);
    chk("t6_first_done_cyc", 64'(done_cyc_a - s), 64'd27);
    tick();
    bus_a.start = 1'b0;
    chk("t6_restart", {bus_a.pe_valid, bus_a.row_idx, bus_a.ox, bus_a.oy, bus_a.oc},
        {1'b1, 2'd0, 2'd0, 2'd0, 1'b0});
    wait_done_a(2);
    chk("t6_second_start_cyc", 64'(b_cyc[24] - s), 64'd29);
    chk("t6_second_done_cyc", 64'(done_cyc_a - s), 64'd55);
    repeat (5) tick();
    chk("t6_total_beats", 64'(nb_a), 64'd48);
    chk("t6_total_done", 64'(nd_a), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/conv_row_scheduler.md
Name: conv_row_scheduler

Overview:
- Sequences one KxK convolution layer (stride 1, no padding) through the PE-row / Accumulator datapath.
- For each output pixel it issues K consecutive kernel-row beats: pe_valid drives the Accumulator in_valid, and row_idx selects the kernel row fed to the PE array.
- It tracks outstanding Accumulator results, applies back-pressure and signals layer completion.

Parameters:
- K, 3: kernel size; K>=2.
- IN_CH, 512: input channels; informational only, kept for parameter alignment with the PE/Accumulator.
- IFM_H, 32: input feature-map height; IFM_H>=K+1.
- IFM_W, 32: input feature-map width; IFM_W>=K+1.
- OUT_CH, 512: output channels; OUT_CH>=2.
- MAX_OUTST, 4: maximum issued-but-unreturned pixels; MAX_OUTST>=1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  layer start request; sampled only in IDLE.
- stall  input  1  downstream hold; honoured at pixel boundaries only.
- acc_out_valid  input  1  Accumulator out_valid, one pulse per finished pixel.
- pe_valid  output  1  row beat valid; drives Accumulator in_valid.
- row_idx  output  $clog2(K)  kernel row of the current beat.
- ox  output  $clog2(IFM_W)  output column of the current pixel.
- oy  output  $clog2(IFM_H)  output row of the current pixel.
- oc  output  $clog2(OUT_CH)  output channel of the current pixel.
- busy  output  1  layer in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0. All counters 0 (issue indices, outstanding, out_cnt). Reset mid-layer aborts immediately; no done pulse is produced.
- Derived constants: OH=IFM_H-K+1, OW=IFM_W-K+1, TOTAL=OUT_CH*OH*OW.
- States:
  - IDLE: start=1 -> ISSUE. Indices, out_cnt and err clear, busy=1 from the next cycle.
  - ISSUE: one beat per cycle.
    - At a pixel boundary (row_idx about to be 0), a beat is issued only if stall=0 and outstanding<MAX_OUTST. Otherwise pe_valid=0 and all indices hold.
    - Once row 0 is issued, rows 1..K-1 follow on consecutive cycles with no gaps. stall and MAX_OUTST are ignored mid-pixel.
    - After row K-1: outstanding+1. Index order is ox fastest, then oy, then oc; each wraps at OW, OH, OUT_CH.
    - After row K-1 of the pixel (oc=OUT_CH-1, oy=OH-1, ox=OW-1): next state DRAIN, pe_valid=0.
  - DRAIN: pe_valid=0 and indices hold their last values. When out_cnt reaches TOTAL -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE. start during DONE is ignored.
- acc_out_valid handling (any non-IDLE state):
  - outstanding-1 and out_cnt+1.
  - Same-cycle increment and decrement: outstanding unchanged.
  - acc_out_valid with outstanding=0, or in IDLE: err=1, sticky until the next accepted start. Counters do not underflow.
- Timing:
  - start sampled high at cycle t -> pe_valid=1, row_idx=0, ox=oy=oc=0 at cycle t+1 (if stall=0).
  - Last acc_out_valid at cycle u -> done=1 at u+1.
- start while busy is ignored. busy=1 covers ISSUE and DRAIN.
- Index outputs are valid only while pe_valid=1.
- Counter widths: outstanding $clog2(MAX_OUTST+1); out_cnt $clog2(TOTAL+1).

Test Plan:
- K=3, IFM_H=IFM_W=4, OUT_CH=2, MAX_OUTST=4; Accumulator model returns a result 2 cycles after each row 2; start pulse at cycle 0:
  - 8 pixels, 24 pe_valid beats, row_idx 0,1,2 repeating.
  - (oc,oy,ox) order: 000,001,010,011,100,101,110,111.
  - done one cycle after the 8th acc_out_valid; busy=0 with done.
- Same config with MAX_OUTST=1 and result latency 5 -> each new row 0 waits for the previous result; pe_valid gaps of 5 cycles between pixels; 8 results total.
- Raise stall during row 1 of pixel 3 for 4 cycles -> rows 1,2 still issue back-to-back; pixel 4 row 0 issues the first cycle after stall falls.
- acc_out_valid pulse in IDLE -> err=1, remains 1 through DRAIN. Next start clears err.
- rst_n low in the middle of DRAIN -> all outputs 0 asynchronously, no done. A new start after release runs the full layer (24 beats) correctly.
- start held high continuously through a layer -> exactly one layer run. A second run begins the first cycle after DONE (start sampled in IDLE).
